axi4_mmio_responder: RTL and testbench
======================================

AXI4_MMIO_RESPONDER -- requirements
Module: axi4_mmio_responder

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of 32-bit registers (power of 2, 2..256).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h4300_0000, byte address of register 0 (NREGS*4-aligned).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have AR channel ports io_M_AXI_ar_valid in 1, ar_ready out 1, ar_bits_addr in 32, ar_bits_id in 12, ar_bits_len in 8, ar_bits_size in 3.
REQ-006 SHALL have AW channel ports io_M_AXI_aw_valid in 1, aw_ready out 1, aw_bits_addr in 32, aw_bits_id in 12, aw_bits_len in 8, aw_bits_size in 3.
REQ-007 SHALL have W channel ports io_M_AXI_w_valid in 1, w_ready out 1, w_bits_data in 32, w_bits_strb in 4, w_bits_last in 1.
REQ-008 SHALL have B channel ports io_M_AXI_b_valid out 1, b_ready in 1, b_bits_id out 12, b_bits_resp out 2.
REQ-009 SHALL have R channel ports io_M_AXI_r_valid out 1, r_ready in 1, r_bits_data out 32, r_bits_id out 12, r_bits_last out 1, r_bits_resp out 2.

Function
REQ-010 SHALL treat every burst as INCR, 4 bytes/beat, beats = len+1; beat address = start + 4*k, addr[1:0] ignored.
REQ-011 SHALL decode a beat in-range iff (addr - BASE_ADDR) < NREGS*4 (32-bit unsigned); index = (addr - BASE_ADDR)>>2.
REQ-012 SHALL run independent read FSM R_IDLE -> R_DATA -> R_IDLE and write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
REQ-013 SHALL drive ar_ready = 1 only in R_IDLE; on ar_valid&&ar_ready, latch id/len/size/addr and enter R_DATA.
REQ-014 SHALL register r_bits_data: captured at the AR handshake edge (beat 0) and at each non-last R handshake edge (next beat), so r_valid is asserted the cycle after AR handshake and beats can stream one per cycle.
REQ-015 SHALL hold r_bits_* stable while r_valid && !r_ready.
REQ-016 SHALL assert r_bits_last on beat len only; R handshake with last returns to R_IDLE; r_bits_id = latched AR id.
REQ-017 SHALL return r_bits_resp 2'b00 and register value in-range; 2'b11 (DECERR) with data 0 out-of-range; 2'b10 (SLVERR) with data 0 on every beat if latched size != 3'd2.
REQ-018 SHALL drive aw_ready = 1 only in W_IDLE; on AW handshake latch id/len/size/addr, enter W_DATA.
REQ-019 SHALL drive w_ready = 1 only in W_DATA; each W handshake writes bytes where strb[i]=1 into the addressed register, effective the next edge.
REQ-020 SHALL suppress the write for out-of-range beats or size != 2, recording the worst error (SLVERR over DECERR over OKAY) for the burst.
REQ-021 SHALL leave W_DATA on the W handshake of beat len (by count, regardless of w_bits_last); a w_bits_last mismatch (early or missing) SHALL set resp SLVERR; beats still count to len.
REQ-022 SHALL assert b_valid in W_RESP with latched id and accumulated resp, hold until b_ready, then return to W_IDLE.
REQ-023 SHALL, when a read capture and a write commit target the same register on the same edge, capture the pre-write value.
REQ-024 SHALL handle address increment past the register window by DECERR on those beats; no wrap into register 0.
REQ-025 SHALL never drop a handshake: no r_valid/b_valid deassertion without ready.

Reset
REQ-026 SHALL, while reset=1 on a clk edge, clear all registers to 0, force both FSMs idle, set r_valid=0, b_valid=0, r_bits_*=0, b_bits_*=0; ar_ready=aw_ready=1 and w_ready=0 the cycle after reset deasserts.
REQ-027 SHALL abort any burst in flight on reset with no further R or B beats for it.

Verification
REQ-028 Single write: AW addr 32'h4300_0008 id 12'h5 len 0 size 2, W data 32'hDEADBEEF strb 4'hF last -> B id 5 resp 00; then AR same addr -> R data DEADBEEF last 1 resp 00.
REQ-029 Burst read len 3 from 32'h4300_0038 (NREGS 16) with r_ready=1 -> 4 consecutive beats: reg14, reg15 resp 00, then two beats data 0 resp 11, last on beat 4.
REQ-030 Byte strobes: reg0=32'h11223344, write data 32'hAABBCCDD strb 4'b0101 -> readback 32'h11BB33DD.
REQ-031 Backpressure: burst read len 1 with r_ready low 5 cycles -> r_valid high, data/id/last unchanged for all 5 cycles.
REQ-032 Errors: write size 3'd3 -> B resp 10, register unchanged; write len 1 with w_bits_last on beat 0 -> B resp 10 after second beat.
REQ-033 Reset mid-burst: assert reset during beat 2 of a len-7 read -> no r_valid after reset, all registers read 0, new AR accepted one cycle after reset drops.

Source files
------------

// File: rtl/axi4_mmio_responder.sv
// AXI4 memory-mapped register responder: NREGS 32-bit registers reached through INCR bursts,
// with independent read and write state machines sharing one register file.
module axi4_mmio_responder #(
  parameter int unsigned NREGS     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_M_AXI_ar_valid,
  output logic        io_M_AXI_ar_ready,
  input  logic [31:0] io_M_AXI_ar_bits_addr,
  input  logic [11:0] io_M_AXI_ar_bits_id,
  input  logic [7:0]  io_M_AXI_ar_bits_len,
  input  logic [2:0]  io_M_AXI_ar_bits_size,
  input  logic        io_M_AXI_aw_valid,
  output logic        io_M_AXI_aw_ready,
  input  logic [31:0] io_M_AXI_aw_bits_addr,
  input  logic [11:0] io_M_AXI_aw_bits_id,
  input  logic [7:0]  io_M_AXI_aw_bits_len,
  input  logic [2:0]  io_M_AXI_aw_bits_size,
  input  logic        io_M_AXI_w_valid,
  output logic        io_M_AXI_w_ready,
  input  logic [31:0] io_M_AXI_w_bits_data,
  input  logic [3:0]  io_M_AXI_w_bits_strb,
  input  logic        io_M_AXI_w_bits_last,
  output logic        io_M_AXI_b_valid,
  input  logic        io_M_AXI_b_ready,
  output logic [11:0] io_M_AXI_b_bits_id,
  output logic [1:0]  io_M_AXI_b_bits_resp,
  output logic        io_M_AXI_r_valid,
  input  logic        io_M_AXI_r_ready,
  output logic [31:0] io_M_AXI_r_bits_data,
  output logic [11:0] io_M_AXI_r_bits_id,
  output logic        io_M_AXI_r_bits_last,
  output logic [1:0]  io_M_AXI_r_bits_resp
);

  localparam int unsigned IDXW        = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [31:0] WIN_BYTES   = 32'(NREGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] regs_q [NREGS];

  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_data_q;
  logic [11:0] r_id_q;
  logic [7:0]  r_len_q, r_cnt_q;
  logic [2:0]  r_size_q;
  logic [1:0]  r_resp_q;
  logic        r_last_q;

  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q;
  logic [11:0] w_id_q;
  logic [7:0]  w_len_q, w_cnt_q;
  logic [2:0]  w_size_q;
  logic [1:0]  w_resp_q;

  logic        ar_hs_c, r_hs_c, rd_cap_c;
  logic [31:0] rd_addr_c, rd_off_c, rd_data_c;
  logic [2:0]  rd_size_c;
  logic [1:0]  rd_resp_c;
  logic [IDXW-1:0] rd_idx_c;

  logic        aw_hs_c, w_hs_c, b_hs_c, wr_en_c, wr_final_c;
  logic [31:0] wr_off_c;
  logic [1:0]  wr_beat_resp_c, wr_resp_acc_c;
  logic [IDXW-1:0] wr_idx_c;

  assign ar_hs_c = io_M_AXI_ar_valid && io_M_AXI_ar_ready;
  assign r_hs_c  = io_M_AXI_r_valid && io_M_AXI_r_ready;
  assign aw_hs_c = io_M_AXI_aw_valid && io_M_AXI_aw_ready;
  assign w_hs_c  = io_M_AXI_w_valid && io_M_AXI_w_ready;
  assign b_hs_c  = io_M_AXI_b_valid && io_M_AXI_b_ready;

  // ---------------- read path ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs_c) r_state_d = R_DATA;
      R_DATA:  if (r_hs_c && r_last_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    io_M_AXI_ar_ready = (r_state_q == R_IDLE);
    io_M_AXI_r_valid  = (r_state_q == R_DATA);
  end

  // Beat lookup: first beat comes from the AR channel, later beats from the advanced address.
  always_comb begin
    rd_addr_c = r_addr_q + 32'd4;
    rd_size_c = r_size_q;
    if (r_state_q == R_IDLE) begin
      rd_addr_c = io_M_AXI_ar_bits_addr & 32'hFFFF_FFFC;
      rd_size_c = io_M_AXI_ar_bits_size;
    end
    rd_off_c  = rd_addr_c - BASE_ADDR;
    rd_idx_c  = rd_off_c[IDXW+1:2];
    rd_data_c = 32'd0;
    rd_resp_c = RESP_OKAY;
    if (rd_size_c != 3'd2)         rd_resp_c = RESP_SLVERR;
    else if (rd_off_c >= WIN_BYTES) rd_resp_c = RESP_DECERR;
    else                           rd_data_c = regs_q[rd_idx_c];
  end

  assign rd_cap_c = ar_hs_c || (r_hs_c && !r_last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_q <= '0;
      r_data_q <= '0;
      r_id_q   <= '0;
      r_len_q  <= '0;
      r_cnt_q  <= '0;
      r_size_q <= '0;
      r_resp_q <= '0;
      r_last_q <= 1'b0;
    end else begin
      if (ar_hs_c) begin
        r_id_q   <= io_M_AXI_ar_bits_id;
        r_len_q  <= io_M_AXI_ar_bits_len;
        r_size_q <= io_M_AXI_ar_bits_size;
        r_cnt_q  <= 8'd0;
        r_last_q <= (io_M_AXI_ar_bits_len == 8'd0);
      end else if (r_hs_c && !r_last_q) begin
        r_cnt_q  <= r_cnt_q + 8'd1;
        r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
      end
      if (rd_cap_c) begin
        r_addr_q <= rd_addr_c;
        r_data_q <= rd_data_c;
        r_resp_q <= rd_resp_c;
      end
    end
  end

  assign io_M_AXI_r_bits_data = r_data_q;
  assign io_M_AXI_r_bits_id   = r_id_q;
  assign io_M_AXI_r_bits_last = r_last_q;
  assign io_M_AXI_r_bits_resp = r_resp_q;

  // ---------------- write path ----------------
  always_ff @(posedge clk) begin
    if (reset) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs_c) w_state_d = W_DATA;
      W_DATA:  if (w_hs_c && wr_final_c) w_state_d = W_RESP;
      W_RESP:  if (b_hs_c) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    io_M_AXI_aw_ready = (w_state_q == W_IDLE);
    io_M_AXI_w_ready  = (w_state_q == W_DATA);
    io_M_AXI_b_valid  = (w_state_q == W_RESP);
  end

  // Per-beat status; SLVERR dominates DECERR, which dominates OKAY.
  always_comb begin
    wr_off_c       = w_addr_q - BASE_ADDR;
    wr_idx_c       = wr_off_c[IDXW+1:2];
    wr_final_c     = (w_cnt_q == w_len_q);
    wr_en_c        = w_hs_c && (w_size_q == 3'd2) && (wr_off_c < WIN_BYTES);
    wr_beat_resp_c = RESP_OKAY;
    if ((w_size_q != 3'd2) || (io_M_AXI_w_bits_last != wr_final_c))
      wr_beat_resp_c = RESP_SLVERR;
    else if (wr_off_c >= WIN_BYTES)
      wr_beat_resp_c = RESP_DECERR;
    if ((w_resp_q == RESP_SLVERR) || (wr_beat_resp_c == RESP_SLVERR))
      wr_resp_acc_c = RESP_SLVERR;
    else if ((w_resp_q == RESP_DECERR) || (wr_beat_resp_c == RESP_DECERR))
      wr_resp_acc_c = RESP_DECERR;
    else
      wr_resp_acc_c = RESP_OKAY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr_q <= '0;
      w_id_q   <= '0;
      w_len_q  <= '0;
      w_cnt_q  <= '0;
      w_size_q <= '0;
      w_resp_q <= '0;
    end else if (aw_hs_c) begin
      w_addr_q <= io_M_AXI_aw_bits_addr & 32'hFFFF_FFFC;
      w_id_q   <= io_M_AXI_aw_bits_id;
      w_len_q  <= io_M_AXI_aw_bits_len;
      w_size_q <= io_M_AXI_aw_bits_size;
      w_cnt_q  <= 8'd0;
      w_resp_q <= RESP_OKAY;
    end else if (w_hs_c) begin
      w_addr_q <= w_addr_q + 32'd4;
      w_cnt_q  <= w_cnt_q + 8'd1;
      w_resp_q <= wr_resp_acc_c;
    end
  end

  assign io_M_AXI_b_bits_id   = w_id_q;
  assign io_M_AXI_b_bits_resp = w_resp_q;

  // Register file; reads on the same edge see the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_en_c) begin
      for (int b = 0; b < 4; b++)
        if (io_M_AXI_w_bits_strb[b]) regs_q[wr_idx_c][8*b +: 8] <= io_M_AXI_w_bits_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi4_mmio_responder.sv
// Directed plus randomized bench for axi4_mmio_responder against an array-based register model.
module tb_axi4_mmio_responder;
  localparam int unsigned NREGS = 16;
  localparam logic [31:0] BASE  = 32'h4300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic        b_valid, b_ready, r_valid, r_ready, r_last;
  logic [31:0] ar_addr, aw_addr, w_data, r_data;
  logic [11:0] ar_id, aw_id, b_id, r_id;
  logic [7:0]  ar_len, aw_len;
  logic [2:0]  ar_size, aw_size;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp, r_resp;

  axi4_mmio_responder #(.NREGS(NREGS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .io_M_AXI_ar_valid(ar_valid), .io_M_AXI_ar_ready(ar_ready), .io_M_AXI_ar_bits_addr(ar_addr),
    .io_M_AXI_ar_bits_id(ar_id), .io_M_AXI_ar_bits_len(ar_len), .io_M_AXI_ar_bits_size(ar_size),
    .io_M_AXI_aw_valid(aw_valid), .io_M_AXI_aw_ready(aw_ready), .io_M_AXI_aw_bits_addr(aw_addr),
    .io_M_AXI_aw_bits_id(aw_id), .io_M_AXI_aw_bits_len(aw_len), .io_M_AXI_aw_bits_size(aw_size),
    .io_M_AXI_w_valid(w_valid), .io_M_AXI_w_ready(w_ready), .io_M_AXI_w_bits_data(w_data),
    .io_M_AXI_w_bits_strb(w_strb), .io_M_AXI_w_bits_last(w_last),
    .io_M_AXI_b_valid(b_valid), .io_M_AXI_b_ready(b_ready), .io_M_AXI_b_bits_id(b_id),
    .io_M_AXI_b_bits_resp(b_resp),
    .io_M_AXI_r_valid(r_valid), .io_M_AXI_r_ready(r_ready), .io_M_AXI_r_bits_data(r_data),
    .io_M_AXI_r_bits_id(r_id), .io_M_AXI_r_bits_last(r_last), .io_M_AXI_r_bits_resp(r_resp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [NREGS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k);
    return (a & ~32'h3) + 32'(4 * k);
  endfunction

  // Expected {resp, data} for one read beat, straight from the address-map rules.
  function automatic logic [33:0] exp_read(input logic [31:0] a, input logic [2:0] size);
    logic [31:0] off;
    off = a - BASE;
    if (size != 3'd2) return {2'b10, 32'h0};
    if (off >= 32'(NREGS * 4)) return {2'b11, 32'h0};
    return {2'b00, model[off / 4]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < int'(NREGS); i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [11:0] id, input logic [7:0] len,
                          input logic [2:0] size, input int bstall);
    int n, sev;
    logic ok;
    logic [31:0] off;
    logic [1:0] exp;
    sev = 0;
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len; aw_size = size;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin ok = aw_ready; @(posedge clk); #1; n++; end
    aw_valid = 1'b0;
    check("aw_handshake", 64'(ok), 64'(1));
    for (int k = 0; k <= int'(len); k++) begin
      w_valid = 1'b1; w_data = wd[k]; w_strb = ws[k]; w_last = wl[k];
      n = 0; ok = 1'b0;
      while (!ok && n < 20) begin ok = w_ready; @(posedge clk); #1; n++; end
      check("w_handshake", 64'(ok), 64'(1));
      off = beat_addr(addr, k) - BASE;
      if (size != 3'd2) sev = 2;
      else if (off >= 32'(NREGS * 4)) begin if (sev < 1) sev = 1; end
      else for (int b = 0; b < 4; b++) if (ws[k][b]) model[off / 4][8*b +: 8] = wd[k][8*b +: 8];
      if (wl[k] != (k == int'(len))) sev = 2;
    end
    w_valid = 1'b0; w_last = 1'b0;
    exp = (sev == 2) ? 2'b10 : (sev == 1) ? 2'b11 : 2'b00;
    check("b_beat", 64'({b_valid, b_id, b_resp}), 64'({1'b1, id, exp}));
    for (int s = 0; s < bstall; s++) begin
      @(posedge clk); #1;
      check("b_hold", 64'({b_valid, b_id, b_resp}), 64'({1'b1, id, exp}));
    end
    b_ready = 1'b1; @(posedge clk); #1; b_ready = 1'b0;
    check("b_done", 64'({b_valid, aw_ready}), 64'(2'b01));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [11:0] id, input logic [7:0] len,
                         input logic [2:0] size, input int smin, input int smax, input int abort_at);
    int n, stall;
    logic ok, aborted;
    logic [33:0] e;
    aborted = 1'b0;
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len; ar_size = size;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin ok = ar_ready; @(posedge clk); #1; n++; end
    ar_valid = 1'b0;
    check("ar_accept_cycles", 64'(n), 64'(1));
    for (int k = 0; k <= int'(len); k++) begin
      e = exp_read(beat_addr(addr, k), size);
      check("r_beat", {15'h0, r_valid, r_data, r_resp, r_last, r_id},
            {15'h0, 1'b1, e[31:0], e[33:32], k == int'(len), id});
      if (k == abort_at) begin aborted = 1'b1; break; end
      stall = $urandom_range(smax, smin);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("r_hold", {15'h0, r_valid, r_data, r_resp, r_last, r_id},
              {15'h0, 1'b1, e[31:0], e[33:32], k == int'(len), id});
      end
      r_ready = 1'b1; @(posedge clk); #1; r_ready = 1'b0;
    end
    if (!aborted) check("r_done", 64'({r_valid, ar_ready}), 64'(2'b01));
  endtask

  task automatic fill_w(input int nb, input logic [3:0] strb);
    for (int k = 0; k < nb; k++) begin
      wd[k] = $urandom; ws[k] = strb; wl[k] = (k == nb - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  sz;
    reset = 1'b1;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0; r_ready = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", 64'({ar_ready, aw_ready, w_ready}), 64'(3'b110));
    check("rst_valid", 64'({r_valid, b_valid}), 64'(0));
    check("rst_rbits", 64'({r_data, r_id, r_last, r_resp}), 64'(0));
    check("rst_bbits", 64'({b_id, b_resp}), 64'(0));
    do_read(BASE, 12'h1, 8'd15, 3'd2, 0, 0, -1);

    // Single write then read back
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(32'h4300_0008, 12'h5, 8'd0, 3'd2, 0);
    do_read(32'h4300_0008, 12'h7, 8'd0, 3'd2, 0, 0, -1);

    // Byte strobes on reg0
    wd[0] = 32'h11223344; ws[0] = 4'hF; wl[0] = 1'b1;
    do_write(BASE, 12'h10, 8'd0, 3'd2, 1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101; wl[0] = 1'b1;
    do_write(BASE, 12'h11, 8'd0, 3'd2, 0);
    do_read(BASE, 12'h12, 8'd0, 3'd2, 0, 0, -1);
    check("strb_readback", 64'(r_data), 64'(32'h11BB33DD));

    // Burst across the top of the window
    fill_w(2, 4'hF);
    do_write(32'h4300_0038, 12'h20, 8'd1, 3'd2, 2);
    do_read(32'h4300_0038, 12'h21, 8'd3, 3'd2, 0, 0, -1);

    // Backpressure: five stalled cycles per beat
    do_read(32'h4300_0038, 12'h22, 8'd1, 3'd2, 5, 5, -1);

    // Errors: bad size, early last, missing last, DECERR tail, bad-size read
    fill_w(1, 4'hF);
    do_write(32'h4300_0004, 12'h30, 8'd0, 3'd3, 0);
    fill_w(2, 4'hF); wl[0] = 1'b1; wl[1] = 1'b0;
    do_write(32'h4300_0010, 12'h31, 8'd1, 3'd2, 0);
    fill_w(2, 4'hF); wl[1] = 1'b0;
    do_write(32'h4300_0018, 12'h32, 8'd1, 3'd2, 0);
    fill_w(4, 4'hF);
    do_write(32'h4300_0034, 12'h33, 8'd3, 3'd2, 0);
    do_read(32'h4300_0000, 12'h34, 8'd15, 3'd2, 0, 1, -1);
    do_read(32'h4300_0004, 12'h35, 8'd1, 3'd1, 0, 0, -1);

    // Reset in the middle of a long read
    do_read(BASE, 12'h40, 8'd7, 3'd2, 0, 0, 2);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    clear_model();
    check("midrst_state", 64'({r_valid, b_valid, ar_ready, aw_ready, w_ready}), 64'(5'b00110));
    for (int c = 0; c < 3; c++) begin
      check("midrst_quiet", 64'({r_valid, b_valid}), 64'(0));
      r_ready = 1'b1; @(posedge clk); #1;
    end
    r_ready = 1'b0;
    do_read(BASE, 12'h41, 8'd15, 3'd2, 0, 0, -1);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      a  = BASE - 32'd8 + 32'($urandom_range(90, 0));
      l  = 8'($urandom_range(4, 0));
      sz = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(7, 0)) : 3'd2;
      if ($urandom_range(1, 0) == 1) begin
        for (int k = 0; k <= int'(l); k++) begin
          wd[k] = $urandom; ws[k] = 4'($urandom_range(15, 0));
          wl[k] = (k == int'(l)) ^ ($urandom_range(9, 0) == 0);
        end
        do_write(a, 12'($urandom_range(4095, 0)), l, sz, $urandom_range(2, 0));
      end else begin
        do_read(a, 12'($urandom_range(4095, 0)), l, sz, 0, 2, -1);
      end
    end
    do_read(BASE, 12'h7FF, 8'd15, 3'd2, 0, 1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
